// File: rtl/cpu_debug_ctrl.sv
// cpu_debug_ctrl
// Execution and debug controller for the processor top level. Produces a
// per-cycle advance enable (cpu_en) for PC, register file and data memory,
// and supports single-step, free-run and run-to-breakpoint operation with
// NUM_BP PC breakpoints. Also keeps cycle / retired-instruction counters and
// drives a paged 16-bit debug display from one of NUM_CH channels.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   step_btn_n        raw active-low step button (asynchronous to clk)
//   run_sw            free-run request level
//   halt_req          synchronous halt request from the core
//   pc                current core PC
//   bp_addr, bp_en    breakpoint addresses (entry i at [i*XLEN +: XLEN]) and enables
//   cpu_en            core advance enable for the current cycle
//   state             00 HALT, 01 STEP, 10 RUN, 11 BREAK
//   bp_hit, bp_idx    in-BREAK flag and index of the breakpoint that caused it
//   cycle_cnt         cycles since reset
//   retired_cnt       cycles with cpu_en=1 since reset
//   dbg_ch, ch_sel    debug channels (channel i at [i*XLEN +: XLEN]) and select
//   page_sel          0 = low 16 bits, 1 = bits [31:16]
//   disp_word, leds   registered display window and channel bits [9:0]
module cpu_debug_ctrl #(
  parameter int XLEN            = 32,
  parameter int NUM_BP          = 4,
  parameter int NUM_CH          = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 32,
  localparam int BP_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
  localparam int CH_W = $clog2(NUM_CH),
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   step_btn_n,
  input  logic                   run_sw,
  input  logic                   halt_req,
  input  logic [XLEN-1:0]        pc,
  input  logic [NUM_BP*XLEN-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  output logic                   cpu_en,
  output logic [1:0]             state,
  output logic                   bp_hit,
  output logic [BP_W-1:0]        bp_idx,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       retired_cnt,
  input  logic [NUM_CH*XLEN-1:0] dbg_ch,
  input  logic [CH_W-1:0]        ch_sel,
  input  logic                   page_sel,
  output logic [15:0]            disp_word,
  output logic [9:0]             leds
);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_STEP  = 2'b01,
    S_RUN   = 2'b10,
    S_BREAK = 2'b11
  } state_t;

  state_t          state_q, state_nxt;
  logic            skip_q;
  logic            sync_p0, sync_p1;
  logic            db_level;
  logic [DB_W-1:0] db_cnt;
  logic            step_pulse;
  logic            match;
  logic [BP_W-1:0] match_idx;
  logic [XLEN-1:0] sel_word;
  logic [15:0]     hi_half;

  // Stage p0/p1: two-flop synchroniser, then debounce on the synchronised level.
  // The synchroniser and accepted level idle at the released (high) value so
  // that leaving reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0    <= 1'b1;
      sync_p1    <= 1'b1;
      db_level   <= 1'b1;
      db_cnt     <= '0;
      step_pulse <= 1'b0;
    end else begin
      sync_p0    <= step_btn_n;
      sync_p1    <= sync_p0;
      step_pulse <= 1'b0;
      if (sync_p1 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_level   <= sync_p1;
        db_cnt     <= '0;
        step_pulse <= ~sync_p1;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (pc == bp_addr[i*XLEN +: XLEN])) begin
        match     = 1'b1;
        match_idx = BP_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    cpu_en    = 1'b0;
    case (state_q)
      S_HALT: begin
        if (run_sw)          state_nxt = S_RUN;
        else if (step_pulse) state_nxt = S_STEP;
      end
      S_STEP: begin
        cpu_en    = 1'b1;
        state_nxt = S_HALT;
      end
      S_RUN: begin
        // skip_q lets the first RUN cycle execute the breakpointed PC.
        cpu_en = !((match && !skip_q) || halt_req);
        if (halt_req || !run_sw)   state_nxt = S_HALT;
        else if (match && !skip_q) state_nxt = S_BREAK;
      end
      S_BREAK: begin
        if (!run_sw)         state_nxt = S_HALT;
        else if (step_pulse) state_nxt = S_STEP;
        else if (halt_req)   state_nxt = S_HALT;
      end
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HALT;
      skip_q      <= 1'b0;
      bp_idx      <= '0;
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      state_q     <= state_nxt;
      skip_q      <= (state_nxt == S_RUN) && (state_q != S_RUN);
      if ((state_q == S_RUN) && (state_nxt == S_BREAK)) bp_idx <= match_idx;
      cycle_cnt   <= cycle_cnt + 1'b1;
      retired_cnt <= retired_cnt + CNT_W'(cpu_en);
    end
  end

  assign state  = state_q;
  assign bp_hit = (state_q == S_BREAK);

  // Out-of-range selects fall through to zero.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) sel_word = dbg_ch[i*XLEN +: XLEN];
    end
  end

  generate
    if (XLEN == 16) begin : g_hi_none
      assign hi_half = 16'h0000;
    end else if (XLEN < 32) begin : g_hi_part
      assign hi_half = {{(32 - XLEN){1'b0}}, sel_word[XLEN-1:16]};
    end else begin : g_hi_full
      assign hi_half = sel_word[31:16];
    end
  endgenerate

  // Stage p1: registered display outputs, one cycle behind the selects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_word <= '0;
      leds      <= '0;
    end else begin
      disp_word <= page_sel ? hi_half : sel_word[15:0];
      leds      <= sel_word[9:0];
    end
  end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
module tb_cpu_debug_ctrl;
  localparam int XLEN   = 32;
  localparam int NUM_BP = 4;
  localparam int NUM_CH = 6;
  localparam int DB     = 16;
  localparam int CNT_W  = 4;
  localparam int CNT_M  = 1 << CNT_W;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   step_btn_n = 1'b1;
  logic                   run_sw = 1'b0;
  logic                   halt_req = 1'b0;
  logic [XLEN-1:0]        pc = '0;
  logic [NUM_BP*XLEN-1:0] bp_addr = '0;
  logic [NUM_BP-1:0]      bp_en = '0;
  logic                   cpu_en;
  logic [1:0]             state;
  logic                   bp_hit;
  logic [1:0]             bp_idx;
  logic [CNT_W-1:0]       cycle_cnt;
  logic [CNT_W-1:0]       retired_cnt;
  logic [NUM_CH*XLEN-1:0] dbg_ch;
  logic [2:0]             ch_sel = '0;
  logic                   page_sel = 1'b0;
  logic [15:0]            disp_word;
  logic [9:0]             leds;

  logic [XLEN-1:0] chw [NUM_CH];

  int checks = 0;
  int errors = 0;
  int ncyc = 0;     // clock edges since reset release
  int nen = 0;      // cpu_en cycles seen by the core model
  int exp_ret = 0;  // instructions the scenarios should have retired

  always #5 clk = ~clk;

  always_comb begin
    dbg_ch = '0;
    for (int i = 0; i < NUM_CH; i++) dbg_ch[i*XLEN +: XLEN] = chw[i];
  end

  cpu_debug_ctrl #(
    .XLEN(XLEN), .NUM_BP(NUM_BP), .NUM_CH(NUM_CH),
    .DEBOUNCE_CYCLES(DB), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step_btn_n(step_btn_n), .run_sw(run_sw),
    .halt_req(halt_req), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .cpu_en(cpu_en), .state(state), .bp_hit(bp_hit), .bp_idx(bp_idx),
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt), .dbg_ch(dbg_ch),
    .ch_sel(ch_sel), .page_sel(page_sel), .disp_word(disp_word), .leds(leds)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: the core advances its PC by 4 on every enabled cycle.
  task automatic tick();
    logic en_s;
    @(negedge clk);
    en_s = cpu_en;
    @(posedge clk);
    ncyc++;
    #1;
    if (en_s) begin
      pc = pc + 32'd4;
      nen++;
    end
  endtask

  task automatic run_to_state(input string tag, input logic [1:0] s, input int lim);
    int k = 0;
    while (state !== s && k < lim) begin
      tick();
      k++;
    end
    check(tag, state, s);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_cycle"}, cycle_cnt, ncyc % CNT_M);
    check({tag, "_retired"}, retired_cnt, exp_ret % CNT_M);
  endtask

  // Run from pc 0 to the first enabled breakpoint, then resume from it.
  task automatic bp_case(input logic [XLEN-1:0] a0, a1, a2, a3, input logic [3:0] en);
    logic [XLEN-1:0] a [4];
    logic [XLEN-1:0] exp_pc;
    int exp_i;
    int n0;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    exp_pc = '1;
    exp_i = 0;
    for (int i = 0; i < 4; i++) begin
      if (en[i] && a[i] < exp_pc) begin
        exp_pc = a[i];
        exp_i = i;
      end
      bp_addr[i*XLEN +: XLEN] = a[i];
    end
    bp_en = en;
    pc = '0;
    n0 = nen;
    run_sw = 1'b1;
    run_to_state("bp_reach_break", 2'b11, 80);
    check("bp_pc", pc, exp_pc);
    check("bp_retire_delta", nen - n0, exp_pc / 4);
    check("bp_idx", bp_idx, exp_i);
    check("bp_hit", bp_hit, 1'b1);
    check("bp_cpu_en", cpu_en, 1'b0);
    exp_ret += int'(exp_pc / 4);
    run_sw = 1'b0;
    tick();
    check("bp_toggle_halt", state, 2'b00);
    check("bp_toggle_hit", bp_hit, 1'b0);
    run_sw = 1'b1;
    n0 = nen;
    tick();
    check("resume_state", state, 2'b10);
    check("resume_skip_en", cpu_en, 1'b1);
    tick();
    check("resume_pc", pc, exp_pc + 32'd4);
    halt_req = 1'b1;
    #1;
    check("halt_req_en", cpu_en, 1'b0);
    run_sw = 1'b0;
    tick();
    halt_req = 1'b0;
    check("halt_req_state", state, 2'b00);
    check("resume_retire_delta", nen - n0, 1);
    exp_ret += 1;
    check_counts("bp_case");
  endtask

  initial begin
    int n0;
    logic saw;
    logic [XLEN-1:0] spc;
    logic sen;
    logic [15:0] prev_disp;
    logic [XLEN-1:0] w;
    logic [15:0] exp_d;

    for (int i = 0; i < NUM_CH; i++) chw[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state, 2'b00);
    check("rst_cpu_en", cpu_en, 1'b0);
    check("rst_bp_hit", bp_hit, 1'b0);
    check("rst_bp_idx", bp_idx, 2'd0);
    check("rst_cycle", cycle_cnt, 0);
    check("rst_retired", retired_cnt, 0);
    check("rst_disp", disp_word, 16'h0);
    check("rst_leds", leds, 10'h0);
    rst_n = 1'b1;
    ncyc = 0;

    // Short press must be rejected, a long hold gives exactly one step.
    step_btn_n = 1'b0;
    repeat (3) tick();
    step_btn_n = 1'b1;
    repeat (25) tick();
    check("short_press_en", nen, 0);
    check("short_press_state", state, 2'b00);
    step_btn_n = 1'b0;
    repeat (40) tick();
    check("long_press_en", nen, 1);
    check("long_press_state", state, 2'b00);
    step_btn_n = 1'b1;
    repeat (25) tick();
    check("release_en", nen, 1);
    exp_ret = 1;
    check_counts("step");

    // Breakpoint 2 at 0x10.
    pc = '0;
    bp_addr[2*XLEN +: XLEN] = 32'h10;
    bp_en = 4'b0100;
    n0 = nen;
    run_sw = 1'b1;
    run_to_state("brk_reach", 2'b11, 60);
    check("brk_pc", pc, 32'h10);
    check("brk_retire_delta", nen - n0, 4);
    check("brk_cpu_en", cpu_en, 1'b0);
    check("brk_hit", bp_hit, 1'b1);
    check("brk_idx", bp_idx, 2'd2);
    exp_ret += 4;
    check_counts("brk");
    repeat (5) tick();
    check("brk_hold_state", state, 2'b11);
    check("brk_hold_en", nen - n0, 4);

    // Step out of BREAK; drop run_sw during STEP so the controller parks in HALT.
    n0 = nen;
    saw = 1'b0;
    spc = '0;
    sen = 1'b0;
    step_btn_n = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (state === 2'b01 && !saw) begin
        saw = 1'b1;
        spc = pc;
        sen = cpu_en;
        run_sw = 1'b0;
      end
    end
    step_btn_n = 1'b1;
    repeat (25) tick();
    check("bstep_seen", saw, 1'b1);
    check("bstep_pc", spc, 32'h10);
    check("bstep_en", sen, 1'b1);
    check("bstep_retire_delta", nen - n0, 1);
    check("bstep_state", state, 2'b00);
    check("bstep_hit", bp_hit, 1'b0);
    check("bstep_idx_held", bp_idx, 2'd2);
    check("bstep_pc_after", pc, 32'h14);
    exp_ret += 1;
    check_counts("bstep");

    // Same address on entries 0 and 3: lowest index wins.
    bp_case(32'h8, 32'h30, 32'h40, 32'h8, 4'b1001);
    for (int r = 0; r < 6; r++) begin
      bp_case(32'(4 * $urandom_range(1, 12)), 32'(4 * $urandom_range(1, 12)),
              32'(4 * $urandom_range(1, 12)), 32'(4 * $urandom_range(1, 12)),
              4'($urandom_range(1, 15)));
    end

    // Asynchronous reset in the middle of a run.
    bp_en = '0;
    pc = '0;
    run_sw = 1'b1;
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", state, 2'b00);
    check("arst_cpu_en", cpu_en, 1'b0);
    check("arst_cycle", cycle_cnt, 0);
    check("arst_retired", retired_cnt, 0);
    run_sw = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ncyc = 0;
    exp_ret = 0;
    repeat (15) tick();
    check("cycle_15", cycle_cnt, 4'd15);
    tick();
    check("cycle_wrap", cycle_cnt, 4'd0);
    check("retired_idle", retired_cnt, 4'd0);

    // Display path.
    for (int i = 0; i < NUM_CH; i++) chw[i] = $urandom;
    chw[5] = 32'hDEADBEEF;
    tick();
    prev_disp = chw[0][15:0];
    check("disp_ch0", disp_word, prev_disp);
    ch_sel = 3'd5;
    page_sel = 1'b0;
    #1;
    check("disp_latency", disp_word, prev_disp);
    tick();
    check("disp_lo", disp_word, 16'hBEEF);
    check("leds_lo", leds, 10'h2EF);
    page_sel = 1'b1;
    tick();
    check("disp_hi", disp_word, 16'hDEAD);
    ch_sel = 3'd7;
    tick();
    check("disp_oor", disp_word, 16'h0);
    check("leds_oor", leds, 10'h0);
    prev_disp = 16'h0;
    for (int r = 0; r < 10; r++) begin
      ch_sel = 3'($urandom_range(0, 7));
      page_sel = 1'($urandom_range(0, 1));
      chw[$urandom_range(0, NUM_CH - 1)] = $urandom;
      w = (int'(ch_sel) < NUM_CH) ? chw[ch_sel] : '0;
      exp_d = page_sel ? w[31:16] : w[15:0];
      #1;
      check("disp_rand_latency", disp_word, prev_disp);
      tick();
      check("disp_rand", disp_word, exp_d);
      check("leds_rand", leds, w[9:0]);
      prev_disp = exp_d;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
